uart_core: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_sampler.sv | 75 +++++++
 rtl/uart_core.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the uart_core slice.
// Imported by uart_core and uart_rx_sampler.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int clk, input int baud);
    return (clk + baud / 2) / baud;
  endfunction

  function automatic int frame_bits(input int data, input int parity,
                                    input int stop);
    return 1 + data + ((parity != 0) ? 1 : 0) + stop;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: synchroniser, falling-edge detect and a
// 3-sample majority vote around the middle of each bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in,
  input  logic active,
  output logic fall,
  output logic sample_bit,
  output logic sample_strobe
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_LO  = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID = CW'(MID);
  localparam logic [CW-1:0] C_HI  = CW'(MID + 1);
  localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

  if (SYNC_STAGES < 2) begin : g_sync_chk
    $error("uart_rx_sampler: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  logic                   prev;
  logic [CW-1:0]          cnt;
  logic                   s0;
  logic                   s1;

  assign line = sync[SYNC_STAGES-1];
  assign fall = prev & ~line;

  // resynchronise the pin; flops idle high like the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_in};
      prev <= line;
    end
  end

  // bit-time counter, held at zero while the receiver is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!active || cnt == C_END) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // capture the two samples that precede the decision point
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else begin
      if (cnt == C_LO) s0 <= line;
      if (cnt == C_MID) s1 <= line;
    end
  end

  assign sample_strobe = active && (cnt == C_HI);
  assign sample_bit = (s0 & s1) | (s0 & line) | (s1 & line);

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART between a valid/ready stream and the pins.
// Define UART_CORE_LOOPBACK_EN to add the internal loopback input.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 48000000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef UART_CORE_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic                 tx_rdy,
  input  logic                 tx_vld,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_uart,
  input  logic                 rx_rdy,
  output logic                 rx_vld,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_uart,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun_err
);

  localparam int CPB = clks_per_bit(CLK_FREQUENCY, BAUD_RATE);
  localparam int FB  = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int CW  = $clog2(CPB);
  localparam int IW  = $clog2(FB);
  localparam int DW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] C_END = CW'(CPB - 1);
  localparam logic [IW-1:0] I_END = IW'(FB - 1);
  localparam logic [DW-1:0] D_END = DW'(DATA_BITS - 1);
  localparam parity_e PAR = parity_e'(PARITY[1:0]);

  if (CPB < 8) begin : g_cpb_chk
    $error("uart_core: CLKS_PER_BIT must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_db_chk
    $error("uart_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("uart_core: STOP_BITS must be 1 or 2");
  end

  tx_state_e      tx_state, tx_state_n;
  logic [CW-1:0]  tx_cnt, tx_cnt_n;
  logic [IW-1:0]  tx_idx, tx_idx_n;
  logic [FB-1:0]  tx_sh, tx_sh_n;
  logic [FB-1:0]  tx_frame;
  logic           tx_q, tx_q_n;

  rx_state_e      rx_state, rx_state_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic [DW-1:0]  rx_idx, rx_idx_n;
  logic           rx_perr, rx_perr_n;
  logic           rx_done;
  logic           rx_src;
  logic           rx_active;
  logic           rx_fall;
  logic           s_bit;
  logic           s_stb;

`ifdef UART_CORE_LOOPBACK_EN
  assign rx_src  = loopback ? tx_q : rx_uart;
  assign tx_uart = loopback | tx_q;
`else
  assign rx_src  = rx_uart;
  assign tx_uart = tx_q;
`endif

  assign tx_rdy    = (tx_state == TX_IDLE);
  assign rx_active = (rx_state != RX_IDLE);

  // assemble start, data, parity and stop bits, LSB first
  always_comb begin
    tx_frame = '1;
    tx_frame[0] = 1'b0;
    tx_frame[DATA_BITS:1] = tx_data;
    if (PAR == PAR_EVEN) begin
      tx_frame[DATA_BITS+1] = ^tx_data;
    end else if (PAR == PAR_ODD) begin
      tx_frame[DATA_BITS+1] = ~^tx_data;
    end
  end

  // TX next state: load on handshake, shift one bit per bit time
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_q_n     = tx_q;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_vld) begin
          tx_state_n = TX_SHIFT;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_sh_n    = tx_frame >> 1;
          tx_q_n     = tx_frame[0];
        end
      end
      TX_SHIFT: begin
        if (tx_cnt == C_END) begin
          tx_cnt_n = '0;
          if (tx_idx == I_END) begin
            tx_state_n = TX_IDLE;
            tx_q_n     = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 1'b1;
            tx_q_n   = tx_sh[0];
            tx_sh_n  = tx_sh >> 1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state register; the pin returns high as soon as reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '1;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_q     <= tx_q_n;
    end
  end

  uart_rx_sampler #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_src),
    .active       (rx_active),
    .fall         (rx_fall),
    .sample_bit   (s_bit),
    .sample_strobe(s_stb)
  );

  // RX next state: act only on the voted bit at each decision point
  always_comb begin
    rx_state_n = rx_state;
    rx_sh_n    = rx_sh;
    rx_idx_n   = rx_idx;
    rx_perr_n  = rx_perr;
    rx_done    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) rx_state_n = RX_START;
      end
      RX_START: begin
        if (s_stb) begin
          rx_state_n = s_bit ? RX_IDLE : RX_DATA;
          rx_idx_n   = '0;
          rx_perr_n  = 1'b0;
        end
      end
      RX_DATA: begin
        if (s_stb) begin
          rx_sh_n  = {s_bit, rx_sh[DATA_BITS-1:1]};
          rx_idx_n = rx_idx + 1'b1;
          if (rx_idx == D_END) begin
            rx_state_n = (PAR == PAR_NONE) ? RX_STOP : RX_PARITY;
          end
        end
      end
      RX_PARITY: begin
        if (s_stb) begin
          rx_perr_n  = s_bit ^ (^rx_sh) ^ (PAR == PAR_ODD);
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (s_stb) begin
          rx_state_n = RX_IDLE;
          rx_done    = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_sh    <= '0;
      rx_idx   <= '0;
      rx_perr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_sh    <= rx_sh_n;
      rx_idx   <= rx_idx_n;
      rx_perr  <= rx_perr_n;
    end
  end

  // deliver the word and error pulses the cycle after the stop decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_vld         <= 1'b0;
      rx_data        <= '0;
      rx_frame_err   <= 1'b0;
      rx_parity_err  <= 1'b0;
      rx_overrun_err <= 1'b0;
    end else begin
      rx_frame_err   <= rx_done & ~s_bit;
      rx_parity_err  <= rx_done & rx_perr;
      rx_overrun_err <= rx_done & rx_vld & ~rx_rdy;
      if (rx_done) begin
        rx_vld  <= 1'b1;
        rx_data <= rx_sh;
      end else if (rx_rdy) begin
        rx_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: three instances (8N1, 8E1 with
// TX wired to RX, 7O2) checked against a frame-level reference model.
module tb_uart_core;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       a_tx_rdy, a_tx_vld, a_tx_uart, a_rx_rdy, a_rx_vld;
  logic       a_rx_uart, a_fe, a_pe, a_oe;
  logic [7:0] a_tx_data, a_rx_data;

  logic       b_tx_rdy, b_tx_vld, b_tx_uart, b_rx_vld, b_fe, b_pe, b_oe;
  logic [7:0] b_tx_data, b_rx_data;

  logic       c_tx_rdy, c_tx_uart, c_rx_vld, c_rx_uart, c_fe, c_pe, c_oe;
  logic [6:0] c_rx_data;

  uart_core #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_a (
    .clk(clk), .reset(reset),
    .tx_rdy(a_tx_rdy), .tx_vld(a_tx_vld), .tx_data(a_tx_data),
    .tx_uart(a_tx_uart), .rx_rdy(a_rx_rdy), .rx_vld(a_rx_vld),
    .rx_data(a_rx_data), .rx_uart(a_rx_uart), .rx_frame_err(a_fe),
    .rx_parity_err(a_pe), .rx_overrun_err(a_oe)
  );

  uart_core #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_b (
    .clk(clk), .reset(reset),
    .tx_rdy(b_tx_rdy), .tx_vld(b_tx_vld), .tx_data(b_tx_data),
    .tx_uart(b_tx_uart), .rx_rdy(1'b1), .rx_vld(b_rx_vld),
    .rx_data(b_rx_data), .rx_uart(b_tx_uart), .rx_frame_err(b_fe),
    .rx_parity_err(b_pe), .rx_overrun_err(b_oe)
  );

  uart_core #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7),
    .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)
  ) u_c (
    .clk(clk), .reset(reset),
    .tx_rdy(c_tx_rdy), .tx_vld(1'b0), .tx_data(7'h00),
    .tx_uart(c_tx_uart), .rx_rdy(1'b1), .rx_vld(c_rx_vld),
    .rx_data(c_rx_data), .rx_uart(c_rx_uart), .rx_frame_err(c_fe),
    .rx_parity_err(c_pe), .rx_overrun_err(c_oe)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] qc[$];
  int a_fe_n = 0, a_pe_n = 0, a_oe_n = 0;
  int b_err_n = 0;
  int c_fe_n = 0, c_pe_n = 0, c_oe_n = 0;

  // collect delivered words and count error-pulse cycles
  always @(negedge clk) begin
    if (a_rx_vld && a_rx_rdy) qa.push_back({1'b0, a_rx_data});
    if (b_rx_vld) qb.push_back({1'b0, b_rx_data});
    if (c_rx_vld) qc.push_back({2'b00, c_rx_data});
    if (a_fe) a_fe_n <= a_fe_n + 1;
    if (a_pe) a_pe_n <= a_pe_n + 1;
    if (a_oe) a_oe_n <= a_oe_n + 1;
    if (b_fe || b_pe || b_oe) b_err_n <= b_err_n + 1;
    if (c_fe) c_fe_n <= c_fe_n + 1;
    if (c_pe) c_pe_n <= c_pe_n + 1;
    if (c_oe) c_oe_n <= c_oe_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference frame: start 0, data LSB first, parity from the count of
  // ones (odd/even total), then stop bits at 1
  function automatic logic [15:0] mk_frame(input logic [8:0] d,
                                           input int nb, input int par);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      if (d[i]) ones++;
    end
    if (par == 2) f[1+nb] = ((ones % 2) == 1);
    if (par == 1) f[1+nb] = ((ones % 2) == 0);
    return f;
  endfunction

  function automatic int qsize(input int which);
    if (which == 0) return qa.size();
    if (which == 1) return qb.size();
    return qc.size();
  endfunction

  task automatic set_line(input int which, input logic v);
    if (which == 0) a_rx_uart = v;
    else c_rx_uart = v;
  endtask

  // drive a serial frame; optionally invert one cycle of one bit
  task automatic drive(input int which, input logic [15:0] f,
                       input int len, input int sp_bit, input int sp_off);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        set_line(which, f[i] ^ (i == sp_bit && c == sp_off));
      end
    end
    @(negedge clk);
    set_line(which, 1'b1);
  endtask

  task automatic wait_q(input int which, input int n, input string tag);
    int k;
    k = 0;
    while (qsize(which) < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(qsize(which) >= n), 32'd1);
  endtask

  // send one word on A and follow the pin cycle by cycle
  task automatic tx_check(input logic [7:0] d, input string tag);
    logic [15:0] f;
    f = mk_frame({1'b0, d}, 8, 0);
    @(negedge clk);
    chk({tag, "_rdy_idle"}, 32'(a_tx_rdy), 32'd1);
    a_tx_data = d;
    a_tx_vld = 1'b1;
    @(negedge clk);
    a_tx_vld = 1'b0;
    a_tx_data = 8'($urandom);
    for (int k = 0; k < 10 * CPB; k++) begin
      chk({tag, "_pin"}, 32'(a_tx_uart), 32'(f[k/CPB]));
      chk({tag, "_rdy_low"}, 32'(a_tx_rdy), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_rdy_back"}, 32'(a_tx_rdy), 32'd1);
    chk({tag, "_pin_idle"}, 32'(a_tx_uart), 32'd1);
  endtask

  task automatic b_send(input logic [7:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!b_tx_rdy && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("b_tx_rdy_wait", 32'(b_tx_rdy), 32'd1);
    b_tx_data = d;
    b_tx_vld = 1'b1;
    @(negedge clk);
    b_tx_vld = 1'b0;
  endtask

  initial begin
    logic [7:0]  bw[6];
    logic [7:0]  r;
    logic [6:0]  r7;
    logic [15:0] f;
    int n;

    reset = 1'b1;
    a_tx_vld = 1'b0; a_tx_data = '0; a_rx_rdy = 1'b1; a_rx_uart = 1'b1;
    b_tx_vld = 1'b0; b_tx_data = '0;
    c_rx_uart = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_tx_rdy", 32'(a_tx_rdy), 32'd1);
    chk("rst_tx_uart", 32'(a_tx_uart), 32'd1);
    chk("rst_rx_vld", 32'(a_rx_vld), 32'd0);
    chk("rst_rx_data", 32'(a_rx_data), 32'd0);
    chk("rst_errs", 32'({a_fe, a_pe, a_oe}), 32'd0);
    chk("rst_c_tx", 32'({c_tx_rdy, c_tx_uart}), 32'd3);
    chk("rst_b_vld", 32'(b_rx_vld), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    tx_check(8'hA5, "tx_a5");
    tx_check(8'($urandom), "tx_rand");

    bw[0] = 8'h3C; bw[1] = 8'hFF; bw[2] = 8'h00;
    for (int i = 3; i < 6; i++) bw[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) b_send(bw[i]);
    wait_q(1, 6, "lb_count");
    for (int i = 0; i < 6; i++) chk("lb_word", 32'(qb[i]), 32'(bw[i]));
    repeat (20) @(negedge clk);
    chk("lb_no_err", 32'(b_err_n), 32'd0);
    chk("lb_extra", 32'(qb.size()), 32'd6);

    f = mk_frame(9'h055, 7, 1);
    f[8] = ~f[8];
    drive(2, f, 11, -1, 0);
    wait_q(2, 1, "par_word_cnt");
    chk("par_word", 32'(qc[0]), 32'h55);
    chk("par_err", 32'(c_pe_n), 32'd1);
    chk("par_no_fe", 32'(c_fe_n), 32'd0);
    r7 = 7'($urandom);
    drive(2, mk_frame({2'b00, r7}, 7, 1), 11, -1, 0);
    wait_q(2, 2, "par_ok_cnt");
    chk("par_ok_word", 32'(qc[1]), 32'(r7));
    chk("par_ok_noerr", 32'(c_pe_n + c_oe_n), 32'd1);

    f = mk_frame(9'h081, 8, 0);
    f[9] = 1'b0;
    drive(0, f, 10, -1, 0);
    wait_q(0, 1, "fe_word_cnt");
    chk("fe_word", 32'(qa[0]), 32'h81);
    chk("fe_pulse", 32'(a_fe_n), 32'd1);
    chk("fe_no_pe", 32'(a_pe_n), 32'd0);

    n = qa.size();
    @(negedge clk); a_rx_uart = 1'b0;
    repeat (3) @(negedge clk);
    a_rx_uart = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_word", 32'(qa.size()), 32'(n));
    chk("glitch_no_fe", 32'(a_fe_n), 32'd1);

    r = 8'($urandom);
    drive(0, mk_frame({1'b0, r}, 8, 0), 10, -1, 0);
    wait_q(0, n + 1, "rx_rand_cnt");
    chk("rx_rand", 32'(qa[n]), 32'(r));

    r = 8'($urandom);
    drive(0, mk_frame({1'b0, r}, 8, 0), 10, 4, 6);
    wait_q(0, n + 2, "spike_cnt");
    chk("spike_word", 32'(qa[n+1]), 32'(r));
    chk("spike_no_fe", 32'(a_fe_n), 32'd1);

    @(posedge clk); #1 a_rx_rdy = 1'b0;
    drive(0, mk_frame(9'h011, 8, 0), 10, -1, 0);
    repeat (3) @(negedge clk);
    chk("ovr_first_vld", 32'(a_rx_vld), 32'd1);
    chk("ovr_first_data", 32'(a_rx_data), 32'h11);
    chk("ovr_none_yet", 32'(a_oe_n), 32'd0);
    drive(0, mk_frame(9'h022, 8, 0), 10, -1, 0);
    repeat (3) @(negedge clk);
    chk("ovr_vld", 32'(a_rx_vld), 32'd1);
    chk("ovr_data", 32'(a_rx_data), 32'h22);
    chk("ovr_pulse", 32'(a_oe_n), 32'd1);
    n = qa.size();
    @(posedge clk); #1 a_rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_drain_cnt", 32'(qa.size()), 32'(n + 1));
    chk("ovr_drain_word", 32'(qa[n]), 32'h22);
    chk("ovr_vld_clear", 32'(a_rx_vld), 32'd0);

    r = 8'($urandom);
    f = mk_frame({1'b0, r}, 8, 0);
    @(negedge clk);
    a_tx_data = r;
    a_tx_vld = 1'b1;
    @(negedge clk);
    a_tx_vld = 1'b0;
    repeat (35) @(negedge clk);
    chk("mid_pin", 32'(a_tx_uart), 32'(f[3]));
    chk("mid_busy", 32'(a_tx_rdy), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("abort_pin", 32'(a_tx_uart), 32'd1);
    chk("abort_rdy", 32'(a_tx_rdy), 32'd1);
    chk("abort_vld", 32'(a_rx_vld), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_pin", 32'(a_tx_uart), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
